// File: rtl/wb_result_checker.sv
// rtl/wb_result_checker.sv - writeback result checker for the pipelined core
//
// Purpose: holds a table of expected register writebacks in program order and
// compares each retired writeback against the next entry, reporting pass/fail,
// match/mismatch counts, the first failing entry and a hang timeout.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   load_en/idx/reg/data write one expected entry (IDLE only)
//   exp_count           number of entries to check, sampled on start
//   start               begin a run (IDLE or DONE)
//   wb_en/wb_reg/wb_data writeback stage tap (RegWrite, register, data)
//   busy, done          state is RUN / DONE
//   pass                run verdict, valid when done
//   timeout             run ended because no writeback arrived in time
//   extra_write         checked writeback seen after the run completed
//   match_count         matching writebacks this run
//   mismatch_count      mismatching writebacks this run
//   fail_idx, fail_data table slot and wb_data of the first mismatch

module wb_result_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT        = 64,
  parameter int IGNORE_XZR     = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic [$clog2(DEPTH)-1:0]    load_idx,
  input  logic [REG_ADDR_WIDTH-1:0]   load_reg,
  input  logic [DATA_WIDTH-1:0]       load_data,
  input  logic [$clog2(DEPTH+1)-1:0]  exp_count,
  input  logic                        start,
  input  logic                        wb_en,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_reg,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic                        extra_write,
  output logic [$clog2(DEPTH+1)-1:0]  match_count,
  output logic [$clog2(DEPTH+1)-1:0]  mismatch_count,
  output logic [$clog2(DEPTH)-1:0]    fail_idx,
  output logic [DATA_WIDTH-1:0]       fail_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = REG_ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [EW-1:0]   tbl [DEPTH];
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;

  logic            checked;
  logic            is_match;
  logic            last;
  logic            start_ok;
  logic [CW-1:0]   mism_next;
  logic [CW-1:0]   clamped;

  // Writes to the zero register are architecturally discarded, so optionally
  // they do not consume a table entry.
  assign checked   = wb_en && !((IGNORE_XZR != 0) && (wb_reg == REG_ADDR_WIDTH'(31)));
  assign is_match  = ({wb_reg, wb_data} == tbl[ptr]);
  assign last      = (CW'(ptr) == (count - CW'(1)));
  assign mism_next = mismatch_count + (is_match ? CW'(0) : CW'(1));
  assign clamped   = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  // In IDLE a simultaneous load wins over start.
  assign start_ok  = start && !((state == IDLE) && load_en);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The expected table is deliberately not reset so a run can be repeated
  // after a reset without reloading.
  always_ff @(posedge clock) begin
    if (!reset && (state == IDLE) && load_en && (32'(load_idx) < DEPTH)) begin
      tbl[load_idx] <= {load_reg, load_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      count          <= '0;
      timer          <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      extra_write    <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
      fail_idx       <= '0;
      fail_data      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            count          <= clamped;
            ptr            <= '0;
            timer          <= '0;
            timeout        <= 1'b0;
            extra_write    <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            fail_idx       <= '0;
            fail_data      <= '0;
            // An empty run completes immediately and trivially passes.
            pass           <= (clamped == '0);
            state          <= (clamped == '0) ? DONE : RUN;
          end else if ((state == DONE) && checked) begin
            extra_write <= 1'b1;
            pass        <= 1'b0;
          end
        end

        RUN: begin
          if (checked) begin
            if (is_match) begin
              match_count <= match_count + CW'(1);
            end else begin
              mismatch_count <= mism_next;
              if (mismatch_count == '0) begin
                fail_idx  <= ptr;
                fail_data <= wb_data;
              end
            end
            ptr   <= ptr + IW'(1);
            timer <= '0;
            if (last) begin
              state <= DONE;
              pass  <= (mism_next == '0);
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state   <= DONE;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_result_checker.sv
// tb/tb_wb_result_checker.sv - self-checking bench for wb_result_checker
module tb_wb_result_checker;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int DEPTH = 16;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [3:0]    load_idx = '0;
  logic [RW-1:0] load_reg = '0;
  logic [DW-1:0] load_data = '0;
  logic [4:0]    exp_count = '0;
  logic          start = 1'b0;
  logic          wb_en = 1'b0;
  logic [RW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          busy, done, pass, timeout, extra_write;
  logic [4:0]    match_count, mismatch_count;
  logic [3:0]    fail_idx;
  logic [DW-1:0] fail_data;

  wb_result_checker #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DEPTH(DEPTH), .TIMEOUT(TO), .IGNORE_XZR(1)
  ) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_reg(load_reg), .load_data(load_data), .exp_count(exp_count), .start(start),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .extra_write(extra_write), .match_count(match_count),
    .mismatch_count(mismatch_count), .fail_idx(fail_idx), .fail_data(fail_data)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the run is described by the list of checked writebacks seen so far;
  // every count and verdict is derived from that list against the table.
  logic [RW+DW-1:0] m_tbl [DEPTH];
  logic [RW+DW-1:0] m_hist [$];
  int m_st = 0;          // 0 idle, 1 run, 2 done
  int m_cnt = 0;
  int m_idle = 0;
  bit m_to = 1'b0;
  bit m_extra = 1'b0;

  function automatic bit is_checked();
    return wb_en && (wb_reg != 5'd31);
  endfunction

  task automatic m_restart();
    m_cnt = (exp_count > 5'd16) ? 16 : int'(exp_count);
    m_hist.delete();
    m_idle = 0;
    m_to = 1'b0;
    m_extra = 1'b0;
    m_st = (m_cnt == 0) ? 2 : 1;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_st = 0; m_hist.delete(); m_cnt = 0; m_idle = 0; m_to = 1'b0; m_extra = 1'b0;
    end else if (m_st == 0) begin
      if (load_en) m_tbl[load_idx] = {load_reg, load_data};
      else if (start) m_restart();
    end else if (m_st == 2) begin
      if (start) m_restart();
      else if (is_checked()) m_extra = 1'b1;
    end else begin
      if (is_checked()) begin
        m_hist.push_back({wb_reg, wb_data});
        m_idle = 0;
        if (m_hist.size() == m_cnt) m_st = 2;
      end else if (m_idle == TO - 1) begin
        m_st = 2;
        m_to = 1'b1;
      end else begin
        m_idle++;
      end
    end
  end

  always @(negedge clock) begin
    if (mon_on) begin
      int mc, mm, fi;
      logic [DW-1:0] fd;
      mc = 0; mm = 0; fi = 0; fd = '0;
      foreach (m_hist[i]) begin
        if (m_hist[i] == m_tbl[i]) mc++;
        else begin
          if (mm == 0) begin fi = i; fd = m_hist[i][DW-1:0]; end
          mm++;
        end
      end
      chk("busy", busy, 64'(m_st == 1));
      chk("done", done, 64'(m_st == 2));
      chk("pass", pass, 64'((m_st == 2) && !m_to && !m_extra && (mm == 0)));
      chk("timeout", timeout, 64'(m_to));
      chk("extra_write", extra_write, 64'(m_extra));
      chk("match_count", match_count, 64'(mc));
      chk("mismatch_count", mismatch_count, 64'(mm));
      chk("fail_idx", fail_idx, 64'(fi));
      chk("fail_data", fail_data, fd);
    end
  end

  logic [DW-1:0] d7 [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int idx, input int r, input logic [DW-1:0] d);
    load_en = 1'b1; load_idx = 4'(idx); load_reg = RW'(r); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    exp_count = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wb(input int r, input logic [DW-1:0] d);
    wb_en = 1'b1; wb_reg = RW'(r); wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic run_good7();
    for (int i = 0; i < 7; i++) wb(2, d7[i]);
  endtask

  initial begin
    d7[0] = 26; d7[1] = 14; d7[2] = 4; d7[3] = 22; d7[4] = 18; d7[5] = 160; d7[6] = 2;
    repeat (2) tick();
    reset = 1'b0;
    mon_on = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_match", match_count, 0);

    // Load and start together in IDLE: load happens, start ignored.
    load_en = 1'b1; start = 1'b1; load_idx = 0; load_reg = 2; load_data = 26; exp_count = 7;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("load_start_busy", busy, 0);
    for (int i = 1; i < 7; i++) load(i, 2, d7[i]);

    // Passing run.
    do_start(7);
    chk("start_busy", busy, 1);
    for (int i = 0; i < 7; i++) begin
      chk("not_done_yet", done, 0);
      wb(2, d7[i]);
    end
    chk("good_done", done, 1);
    chk("good_pass", pass, 1);
    chk("good_match", match_count, 7);
    chk("good_mism", mismatch_count, 0);
    chk("good_timeout", timeout, 0);

    // Single mismatch at entry 2.
    do_start(7);
    for (int i = 0; i < 7; i++) wb(2, (i == 2) ? 64'd5 : d7[i]);
    chk("mm1_pass", pass, 0);
    chk("mm1_mism", mismatch_count, 1);
    chk("mm1_match", match_count, 6);
    chk("mm1_fidx", fail_idx, 2);
    chk("mm1_fdata", fail_data, 5);

    // Second mismatch later does not move the first-failure capture.
    do_start(7);
    for (int i = 0; i < 7; i++) wb(2, (i == 2) ? 64'd5 : (i == 4) ? 64'd77 : d7[i]);
    chk("mm2_mism", mismatch_count, 2);
    chk("mm2_fidx", fail_idx, 2);
    chk("mm2_fdata", fail_data, 5);

    // X31 writes interleaved are ignored.
    do_start(7);
    for (int i = 0; i < 7; i++) begin
      wb(31, 64'hFF);
      wb(2, d7[i]);
    end
    chk("xzr_pass", pass, 1);
    chk("xzr_match", match_count, 7);

    // Extra write after completion.
    wb(2, 26);
    chk("extra_flag", extra_write, 1);
    chk("extra_pass", pass, 0);
    chk("extra_match", match_count, 7);

    // Restart from DONE with 3 entries, then let it time out.
    do_start(3);
    chk("restart_busy", busy, 1);
    chk("restart_match", match_count, 0);
    chk("restart_extra", extra_write, 0);
    wb(2, 26);
    wb(2, 14);
    repeat (TO - 1) tick();
    chk("to_not_yet", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_match", match_count, 2);

    // Reset mid-run after 3 matches.
    do_start(7);
    for (int i = 0; i < 3; i++) wb(2, d7[i]);
    chk("pre_reset_match", match_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match_count, 0);

    // Fill the rest of the table for the clamp run later.
    for (int i = 7; i < 16; i++) load(i, i, 64'(i * 3));

    // Original table survives reset.
    do_start(7);
    run_good7();
    chk("post_rst_pass", pass, 1);
    chk("post_rst_match", match_count, 7);

    // Empty run.
    do_start(0);
    chk("zero_done", done, 1);
    chk("zero_pass", pass, 1);

    // exp_count above DEPTH clamps to 16 entries.
    do_start(20);
    run_good7();
    for (int i = 7; i < 15; i++) wb(i, 64'(i * 3));
    chk("clamp_not_yet", done, 0);
    wb(15, 64'd45);
    chk("clamp_done", done, 1);
    chk("clamp_pass", pass, 1);
    chk("clamp_match", match_count, 16);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
